// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC, issuing imem reads and buffering returned words
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o, imem_gnt_i  read request handshake
//   imem_rvalid_i, imem_rdata_i          in-order read responses
//   redirect_i, redirect_pc_i            taken branch / JAL restart
//   instr_valid_o, instr_ready_i         head-of-buffer handshake to decode
//   instr_o, pc_o, pc_plus4_o            head instruction, its PC and PC+4
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  instr_ready_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(4);
  logic [DATA_WIDTH-1:0] fetch_pc, resp_pc, target;
  logic [DATA_WIDTH-1:0] buf_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, occ, outstanding, outstanding_nxt, discard;
  logic gnt_fire, drop, push, pop;
  // A request is only issued when its response is guaranteed a buffer slot,
  // so a push can never find the buffer full.
  always_comb begin
    occ = wr_ptr - rd_ptr;
    imem_req_o = rst_ni && !redirect_i &&
                 (({1'b0, occ} + {1'b0, outstanding}) < (AW+2)'(FIFO_DEPTH));
    gnt_fire = imem_req_o && imem_gnt_i;
    outstanding_nxt = outstanding + (AW+1)'(gnt_fire) - (AW+1)'(imem_rvalid_i);
    drop = imem_rvalid_i && (discard != '0);
    push = imem_rvalid_i && !drop && !redirect_i;
    instr_valid_o = occ != '0;
    pop = instr_valid_o && instr_ready_i && !redirect_i;
    target = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  end
  assign imem_addr_o = fetch_pc;
  assign instr_o = instr_valid_o ? buf_instr[rd_ptr[AW-1:0]] : '0;
  assign pc_o = instr_valid_o ? buf_pc[rd_ptr[AW-1:0]] : '0;
  assign pc_plus4_o = pc_o + STEP;
  // On redirect every request still in flight (including one granted this
  // cycle, net of a response arriving this cycle) must be thrown away.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= target;
        resp_pc <= target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        discard <= outstanding_nxt;
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + STEP;
        if (push) resp_pc <= resp_pc + STEP;
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (drop) discard <= discard - (AW+1)'(1);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr[wr_ptr[AW-1:0]] <= imem_rdata_i;
      buf_pc[wr_ptr[AW-1:0]] <= resp_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a queue-based fetch model
module tb_fetch_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, instr_ready_i, instr_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, pc_o, pc_plus4_o;
  fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_ready_i(instr_ready_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    bit keep;
    int due;
  } fl_t;
  fl_t inflight[$];
  logic [31:0] buffer[$];
  logic [31:0] fetch_pc = 32'h0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int p_gnt = 100, p_rv = 100, p_rdy = 100, lat_max = 1;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a >> 2;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic idle_inputs();
    imem_gnt_i = 0;
    imem_rvalid_i = 0;
    imem_rdata_i = 32'h0;
    redirect_i = 0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 0;
  endtask
  task automatic model_reset();
    inflight.delete();
    buffer.delete();
    fetch_pc = 32'h0;
  endtask
  task automatic step(input bit rd, input logic [31:0] rpc);
    logic exp_req, exp_val, pop, rv, gnt;
    logic [31:0] head;
    fl_t e;
    @(negedge clk);
    rv = (inflight.size() > 0) && (inflight[0].due <= cyc) && ($urandom_range(99) < p_rv);
    gnt = $urandom_range(99) < p_gnt;
    redirect_i = rd;
    redirect_pc_i = rpc;
    instr_ready_i = $urandom_range(99) < p_rdy;
    imem_gnt_i = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i = rv ? word_at(inflight[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_req = ((buffer.size() + inflight.size()) < 2) && !rd;
    exp_val = buffer.size() > 0;
    head = exp_val ? buffer[0] : 32'h0;
    check("req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) check("addr", imem_addr_o, fetch_pc);
    check("valid", 32'(instr_valid_o), 32'(exp_val));
    if (exp_val) begin
      check("pc", pc_o, head);
      check("instr", instr_o, word_at(head));
      check("pc4", pc_plus4_o, head + 32'd4);
    end
    pop = exp_val && instr_ready_i && !rd;
    @(posedge clk);
    cyc++;
    if (pop) void'(buffer.pop_front());
    if (rv) begin
      e = inflight.pop_front();
      if (e.keep && !rd) buffer.push_back(e.addr);
    end
    if (exp_req && gnt) begin
      e.addr = fetch_pc;
      e.keep = 1;
      e.due = cyc + $urandom_range(lat_max - 1, 0);
      inflight.push_back(e);
      fetch_pc += 32'd4;
    end
    if (rd) begin
      foreach (inflight[i]) inflight[i].keep = 0;
      buffer.delete();
      fetch_pc = {rpc[31:2], 2'b00};
    end
  endtask
  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h4);
    rst_n = 1;
    step(0, 0);
    step(0, 0);
    #1;
    check("lat_valid", 32'(instr_valid_o), 32'h1);
    check("lat_pc", pc_o, 32'h0);
    check("lat_instr", instr_o, 32'h0);
    repeat (6) step(0, 0);
    p_rdy = 0;
    repeat (10) step(0, 0);
    check("stall_full", 32'(instr_valid_o), 32'h1);
    p_rdy = 100;
    repeat (6) step(0, 0);
    lat_max = 4;
    p_rdy = 0;
    repeat (2) step(0, 0);
    p_rdy = 100;
    step(0, 0);
    step(1, 32'h100);
    repeat (12) step(0, 0);
    lat_max = 1;
    step(0, 0);
    step(1, 32'h200);
    repeat (4) step(0, 0);
    step(1, 32'h103);
    repeat (4) step(0, 0);
    step(1, 32'hFFFF_FFF8);
    repeat (6) step(0, 0);
    p_rdy = 0;
    repeat (6) step(0, 0);
    #1;
    rst_n = 0;
    idle_inputs();
    #1;
    check("arst_req", 32'(imem_req_o), 32'h0);
    check("arst_valid", 32'(instr_valid_o), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    p_rdy = 100;
    repeat (4) step(0, 0);
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) begin
        p_gnt = $urandom_range(100, 30);
        p_rv = $urandom_range(100, 30);
        p_rdy = $urandom_range(100, 20);
        lat_max = $urandom_range(4, 1);
      end
      if ($urandom_range(19) == 0)
        step(1, ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
      else
        step(0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
